// File: rtl/ascii_term_buffer.sv
// Text-terminal character buffer with cursor, auto-wrap, backspace and hardware scrolling.
// Optional cursor blink overlay on the read port is enabled by defining CURSOR_BLINK_EN.
module ascii_term_buffer #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int CW        = 7,
  parameter int RW        = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_ascii,
  output logic          in_ready,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic          busy,
  output logic [7:0]    char_cnt
);

  localparam int            AW      = RW + CW;
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_X  = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_X  = (CW + 1)'(COLS);
  localparam logic [7:0]    SPACE   = 8'h20;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  // Logical-to-physical row rotation; both operands are < ROWS so one subtract suffices.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow, input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= ROWS_X) sum = sum - ROWS_X;
    return sum[RW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] top_q, top_d;
  logic [RW-1:0] cnt_row_q, cnt_row_d;
  logic [CW-1:0] cnt_col_q, cnt_col_d;
  logic [7:0]    char_cnt_q, char_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic [7:0]    rd_char_q, rd_char_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          newline;

  logic [7:0]    mem [0:(2**AW)-1];

  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    top_d      = top_q;
    cnt_row_d  = cnt_row_q;
    cnt_col_d  = cnt_col_q;
    char_cnt_d = char_cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = SPACE;
    newline    = 1'b0;
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = {cnt_row_q, cnt_col_q};
        if (cnt_col_q == COL_MAX) begin
          cnt_col_d = '0;
          if (cnt_row_q == ROW_MAX) begin
            cnt_row_d  = '0;
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            cnt_row_d = cnt_row_q + RW'(1);
          end
        end else begin
          cnt_col_d = cnt_col_q + CW'(1);
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = {phys_row(cur_row_q, top_q), cnt_col_q};
        if (cnt_col_q == COL_MAX) begin
          cnt_col_d  = '0;
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_col_d = cnt_col_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
            we         = 1'b1;
            wdata      = in_ascii;
            waddr      = {phys_row(cur_row_q, top_q), cur_col_q};
            char_cnt_d = char_cnt_q + 8'd1;
            if (cur_col_q != COL_MAX) cur_col_d = cur_col_q + CW'(1);
            else newline = 1'b1;
          end else if (in_ascii == 8'h0A || in_ascii == 8'h0D) begin
            newline = 1'b1;
          end else if (in_ascii == 8'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - CW'(1);
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - RW'(1);
              cur_col_d = COL_MAX;
            end
            we    = 1'b1;
            waddr = {phys_row(cur_row_d, top_q), cur_col_d};
          end
          if (newline) begin
            cur_col_d = '0;
            if (cur_row_q != ROW_MAX) begin
              cur_row_d = cur_row_q + RW'(1);
            end else begin
              // The old top physical row becomes the new bottom line and is blanked by CLEAR.
              top_d      = (top_q == ROW_MAX) ? '0 : top_q + RW'(1);
              cnt_col_d  = '0;
              state_d    = S_CLEAR;
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d    = S_INIT;
        cnt_row_d  = '0;
        cnt_col_d  = '0;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
    endcase
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`endif

  always_comb begin
    rd_char_d = mem[{phys_row(rd_row, top_q), rd_col}];
    if ({1'b0, rd_row} >= ROWS_X || {1'b0, rd_col} >= COLS_X) rd_char_d = SPACE;
`ifdef CURSOR_BLINK_EN
    if (blink_q && rd_row == cur_row_q && rd_col == cur_col_q) rd_char_d = 8'h5F;
`endif
  end

  // RAM has no reset; a write and a read of the same cell in one cycle yields the old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      top_q      <= '0;
      cnt_row_q  <= '0;
      cnt_col_q  <= '0;
      char_cnt_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      rd_char_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      top_q      <= top_d;
      cnt_row_q  <= cnt_row_d;
      cnt_col_q  <= cnt_col_d;
      char_cnt_q <= char_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      rd_char_q  <= rd_char_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign rd_char    = rd_char_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign char_cnt   = char_cnt_q;

endmodule

// File: tb/tb_ascii_term_buffer.sv
// Scoreboard bench for ascii_term_buffer at COLS=4, ROWS=3 against a shifting-screen reference model.
module tb_ascii_term_buffer;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int CW   = 2;
  localparam int RW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_ascii = 8'h00;
  logic          in_ready;
  logic [RW-1:0] rd_row = '0;
  logic [CW-1:0] rd_col = '0;
  logic [7:0]    rd_char;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic          busy;
  logic [7:0]    char_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] scr [ROWS][COLS];
  int         mrow, mcol, mcnt;
  int         bcyc;
  logic [7:0] exp_q [$];
  string      nm_q [$];
  logic       rd_issue = 1'b0;
  logic [7:0] mon_e, mon_got;
  string      mon_nm;

  ascii_term_buffer #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ascii(in_ascii), .in_ready(in_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy), .char_cnt(char_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) bcyc <= 0;
    else bcyc <= bcyc + 1;
  end

  // Scoreboard drain: one expected read value per issued address.
  always @(posedge clk) begin
    if (rd_issue) begin
      #1;
      mon_got = rd_char;
      mon_e   = exp_q.pop_front();
      mon_nm  = nm_q.pop_front();
      checks++;
      if (mon_got !== mon_e) begin
        errors++;
        $display("FAIL %s: rd_char=%h expected %h", mon_nm, mon_got, mon_e);
      end
    end
  end

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    mrow = 0; mcol = 0; mcnt = 0;
  endfunction

  function automatic void model_nl();
    mcol = 0;
    if (mrow < ROWS - 1) mrow++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow][mcol] = b;
      mcnt = (mcnt + 1) % 256;
      if (mcol < COLS - 1) mcol++;
      else model_nl();
    end else if (b == 8'h0A || b == 8'h0D) begin
      model_nl();
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin mrow--; mcol = COLS - 1; end
      scr[mrow][mcol] = 8'h20;
    end
  endfunction

  function automatic logic [7:0] exp_read(input int r, input int c);
    logic [7:0] e;
    if (r >= ROWS || c >= COLS) return 8'h20;
    e = scr[r][c];
`ifdef CURSOR_BLINK_EN
    if (r == mrow && c == mcol && ((bcyc / 4) % 2 == 1)) e = 8'h5F;
`endif
    return e;
  endfunction

  task automatic issue_read(input int r, input int c, input string nm);
    @(negedge clk);
    rd_row = RW'(r);
    rd_col = CW'(c);
    exp_q.push_back(exp_read(r, c));
    nm_q.push_back(nm);
    rd_issue = 1'b1;
    @(posedge clk);
    #2;
    rd_issue = 1'b0;
  endtask

  task automatic scan_screen(input string nm);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) issue_read(r, c, nm);
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_ascii = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 for byte %h", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_byte(b);
    end
  endtask

  task automatic reset_dut(output int n, output bit busy_ok);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n; bit bok;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_flags: busy/in_ready=%b expected 10", {busy, in_ready});
    end
    checks++;
    if ({cursor_row, cursor_col, char_cnt, rd_char} !== '0) begin
      errors++;
      $display("FAIL reset_values: row=%0d col=%0d cnt=%0d rd=%h expected zeros",
               cursor_row, cursor_col, char_cnt, rd_char);
    end
    reset_dut(n, bok);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL init_len: cycles=%0d expected 12", n); end
    checks++;
    if (!bok || busy !== 1'b0) begin
      errors++; $display("FAIL init_busy: busy_ok=%b busy=%b expected 1/0", bok, busy);
    end
    scan_screen("init_blank");
    checks++;
    if (cursor_row !== 0 || cursor_col !== 0) begin
      errors++; $display("FAIL init_cursor: (%0d,%0d) expected (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_print();
    int n; bit bok;
    reset_dut(n, bok);
    send(8'h41);
    send(8'h42);
    issue_read(0, 0, "print_00");
    @(negedge clk);
    rd_row = 0; rd_col = 1;
    #1;
    checks++;
    if (rd_char !== 8'h41) begin
      errors++; $display("FAIL read_latency: rd_char=%h expected 41 (old address)", rd_char);
    end
    issue_read(0, 1, "print_01");
    issue_read(3, 0, "read_oob_row");
    issue_read(3, 3, "read_oob_corner");
    checks++;
    if (cursor_row !== 0 || cursor_col !== 2 || char_cnt !== 8'd2) begin
      errors++;
      $display("FAIL print_state: (%0d,%0d) cnt=%0d expected (0,2) cnt=2", cursor_row, cursor_col, char_cnt);
    end
  endtask

  task automatic test_wrap_scroll();
    int n; bit bok;
    reset_dut(n, bok);
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    scan_screen("wrap_screen");
    checks++;
    if (cursor_row !== 1 || cursor_col !== 1) begin
      errors++; $display("FAIL wrap_cursor: (%0d,%0d) expected (1,1)", cursor_row, cursor_col);
    end
    for (int i = 0; i < 6; i++) send(8'h36 + 8'(i));
    send(8'h0D);
    n = 0;
    while ((busy || !in_ready) && n < 40) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL clear_flags: busy=%b in_ready=%b expected 1/0", busy, in_ready);
      end
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL clear_len: cycles=%0d expected 4", n); end
    scan_screen("scroll_screen");
    checks++;
    if (cursor_row !== 2 || cursor_col !== 0) begin
      errors++; $display("FAIL scroll_cursor: (%0d,%0d) expected (2,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_backspace();
    int n; bit bok;
    reset_dut(n, bok);
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i));
    send(8'h08);
    checks++;
    if (cursor_row !== 0 || cursor_col !== 3 || char_cnt !== 8'd4) begin
      errors++;
      $display("FAIL bs_wrap: (%0d,%0d) cnt=%0d expected (0,3) cnt=4", cursor_row, cursor_col, char_cnt);
    end
    issue_read(0, 3, "bs_cell");
    repeat (4) send(8'h08);
    checks++;
    if (cursor_row !== 0 || cursor_col !== 0) begin
      errors++; $display("FAIL bs_origin: (%0d,%0d) expected (0,0)", cursor_row, cursor_col);
    end
    send(8'h07);
    checks++;
    if (cursor_row !== 0 || cursor_col !== 0 || char_cnt !== 8'd4) begin
      errors++;
      $display("FAIL ignored_code: (%0d,%0d) cnt=%0d expected (0,0) cnt=4", cursor_row, cursor_col, char_cnt);
    end
    scan_screen("bs_screen");
  endtask

  task automatic test_collision();
    int n; bit bok;
    reset_dut(n, bok);
    @(negedge clk);
    rd_row = 0; rd_col = 0;
    in_valid = 1'b1; in_ascii = 8'h55;
    exp_q.push_back(exp_read(0, 0));
    nm_q.push_back("collision_old");
    rd_issue = 1'b1;
    @(posedge clk);
    #2;
    rd_issue = 1'b0;
    in_valid = 1'b0;
    model_byte(8'h55);
    issue_read(0, 0, "collision_new");
  endtask

  task automatic test_back_to_back();
    int n; bit bok;
    reset_dut(n, bok);
    for (int i = 0; i < 256; i++) send(8'h20 + 8'(i % 95));
    checks++;
    if (char_cnt !== 8'(mcnt) || cursor_row !== RW'(mrow) || cursor_col !== CW'(mcol)) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%0d (%0d,%0d) expected cnt=%0d (%0d,%0d)",
               char_cnt, cursor_row, cursor_col, mcnt, mrow, mcol);
    end
    scan_screen("b2b_screen");
  endtask

  task automatic test_rst_clear();
    int n; bit bok;
    reset_dut(n, bok);
    send(8'h41);
    send(8'h0A);
    send(8'h0A);
    send(8'h0A);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || cursor_row !== 0) begin
      errors++;
      $display("FAIL rst_abort: busy=%b in_ready=%b row=%0d expected 1/0/0", busy, in_ready, cursor_row);
    end
    reset_dut(n, bok);
    checks++;
    if (n !== 12 || !bok) begin
      errors++; $display("FAIL rst_init_len: cycles=%0d busy_ok=%b expected 12/1", n, bok);
    end
    scan_screen("rst_screen");
  endtask

  task automatic test_blink();
    int n; bit bok;
    reset_dut(n, bok);
    for (int i = 0; i < 12; i++) issue_read(0, 0, "blink_cursor");
    for (int i = 0; i < 6; i++) issue_read(1, 2, "blink_other");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_print();
    test_wrap_scroll();
    test_backspace();
    test_collision();
    test_back_to_back();
    test_rst_clear();
    test_blink();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
